// File: rtl/adcif_pkg.sv
// Definitions shared by the I2S capture and playback interfaces.
// Word size, slot polarity and frame-tracking state encodings.
package adcif_pkg;

    localparam int   I2S_WIDTH = 24;
    localparam logic LRCK_LEFT = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_LEFT  = 2'd2,
        S_RIGHT = 2'd3
    } i2s_state_t;

endpackage

// File: rtl/adcif_sync.sv
// Multi-stage synchronizer for the I2S inputs.
// One edge-detected line (bit clock) plus plain synced level lines.
module i2s_sync #(
    parameter int STAGES = 2,
    parameter int LW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          edge_in,
    input  logic [LW-1:0] lvl_in,
    output logic [LW-1:0] lvl_out,
    output logic          rise
);

    logic [LW:0] ff [STAGES];
    logic        dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '0;
            dly  <= 1'b0;
            rise <= 1'b0;
        end else begin
            ff[0] <= {lvl_in, edge_in};
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
            dly  <= ff[STAGES-1][0];
            rise <= ff[STAGES-1][0] & ~dly;
        end
    end

    assign lvl_out = ff[STAGES-1][LW:1];

endmodule

// File: rtl/adcif.sv
// I2S receive interface: oversampled capture of LRCK/BCK/DATA,
// MSB-first deserialization and stereo-pair valid/ready output.
module adcif
    import adcif_pkg::*;
#(
    parameter int WIDTH       = I2S_WIDTH,
    parameter int DELAY       = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i2s_lrck,
    input  logic             i2s_bck,
    input  logic             i2s_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             overrun
);

    localparam int CW = $clog2(DELAY + WIDTH + 1);
    localparam logic [CW-1:0] POS_MAX = CW'(DELAY + WIDTH);
    localparam logic [CW-1:0] POS_LO  = CW'(DELAY);

    logic             bck_rise;
    logic             lrck_s;
    logic             data_s;
    logic             lrck_prev;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    pos_n;
    logic [CW-1:0]    off;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [WIDTH-1:0] left_hold;
    logic             edge_any;
    logic             to_left;
    logic             to_right;
    logic             clr;
    logic             hold_ld;
    logic             commit;
    i2s_state_t       state;
    i2s_state_t       state_n;

    i2s_sync #(
        .STAGES (SYNC_STAGES),
        .LW     (2)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .edge_in (i2s_bck),
        .lvl_in  ({i2s_data, i2s_lrck}),
        .lvl_out ({data_s, lrck_s}),
        .rise    (bck_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        edge_any = bck_rise && (lrck_s != lrck_prev);
        to_left  = edge_any && (lrck_s == LRCK_LEFT);
        to_right = edge_any && (lrck_s != LRCK_LEFT);
        clr      = 1'b0;
        hold_ld  = 1'b0;
        commit   = 1'b0;
        state_n  = state;
        unique case (state)
            S_IDLE:  if (bck_rise) state_n = S_SYNC;
            S_SYNC:  if (to_left) begin
                clr     = 1'b1;
                state_n = S_LEFT;
            end
            S_LEFT:  if (to_right) begin
                hold_ld = 1'b1;
                clr     = 1'b1;
                state_n = S_RIGHT;
            end
            S_RIGHT: if (to_left) begin
                commit  = 1'b1;
                clr     = 1'b1;
                state_n = S_LEFT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bit position of the current rise; the boundary bit itself is slot position 0.
    always_comb begin
        if (edge_any)            pos_n = '0;
        else if (pos == POS_MAX) pos_n = pos;
        else                     pos_n = pos + CW'(1);
        off     = pos_n - POS_LO;
        shreg_n = clr ? '0 : shreg;
        if (bck_rise) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (off == CW'(WIDTH - 1 - i)) shreg_n[i] = data_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lrck_prev    <= 1'b0;
            pos          <= '0;
            shreg        <= '0;
            left_hold    <= '0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            shreg   <= shreg_n;
            overrun <= 1'b0;
            if (bck_rise) begin
                lrck_prev <= lrck_s;
                pos       <= pos_n;
            end
            if (hold_ld) left_hold <= shreg;
            if (commit) begin
                left_data    <= left_hold;
                right_data   <= shreg;
                sample_valid <= 1'b1;
                overrun      <= sample_valid && !sample_ready;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adcif.sv
// Directed bench for adcif: left-justified and Philips framing,
// short slots, backpressure, accept-on-commit and mid-frame reset.
module tb_adcif;

    logic clk = 1'b0;
    logic rst;
    logic lrck;
    logic bck;
    logic data;
    logic ready;

    logic        v0, v1, o0, o1;
    logic [23:0] l0, r0, l1, r1;

    always #5 clk = ~clk;

    adcif #(.WIDTH(24), .DELAY(0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .i2s_lrck(lrck), .i2s_bck(bck),
        .i2s_data(data), .sample_valid(v0), .sample_ready(ready),
        .left_data(l0), .right_data(r0), .overrun(o0)
    );

    adcif #(.WIDTH(24), .DELAY(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst(rst), .i2s_lrck(lrck), .i2s_bck(bck),
        .i2s_data(data), .sample_valid(v1), .sample_ready(ready),
        .left_data(l1), .right_data(r1), .overrun(o1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vcnt = 0;
    int          vcyc = 0;
    int          acc  = 0;
    int          ocnt = 0;
    logic [23:0] cl0 = '0, cr0 = '0, cl1 = '0, cr1 = '0;
    logic        v0p = 1'b0, v1p = 1'b0;

    always @(negedge clk) begin
        if (v0 && !v0p) begin
            vcnt++;
            vcyc = cyc;
            cl0  = l0;
            cr0  = r0;
        end
        if (v1 && !v1p) begin
            cl1 = l1;
            cr1 = r1;
        end
        if (v0 && ready) acc++;
        if (o0) ocnt++;
        v0p = v0;
        v1p = v1;
    end

    int   total  = 0;
    int   passed = 0;
    int   ref_cyc = 0;
    logic last_l = 1'b1;
    logic carry  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One BCK period of 8 clk: 4 low, 4 high; optional ready pulse
    // landing on the commit edge three clocks after the rise is sampled.
    task automatic send_bit(input logic l, input logic d, input bit pulse);
        lrck = l;
        data = d;
        bck  = 1'b0;
        tick(4);
        bck = 1'b1;
        if (l == 1'b0 && last_l == 1'b1) ref_cyc = cyc + 1;
        last_l = l;
        if (pulse) begin
            tick(3);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
        end else begin
            tick(4);
        end
    endtask

    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                              input int n, input bit ph, input bit pulse);
        logic d;
        for (int i = 0; i < n; i++) begin
            if (!ph)         d = lw[n-1-i];
            else if (i == 0) d = carry;
            else             d = lw[n-i];
            send_bit(1'b0, d, pulse && i == 0);
        end
        carry = lw[0];
        for (int i = 0; i < n; i++) begin
            if (!ph)         d = rw[n-1-i];
            else if (i == 0) d = carry;
            else             d = rw[n-i];
            send_bit(1'b1, d, 1'b0);
        end
        carry = rw[0];
    endtask

    typedef struct {
        logic [31:0] lw;
        logic [31:0] rw;
        int          n;
        bit          ph;
        logic [23:0] el0;
        logic [23:0] er0;
        logic [23:0] el1;
        logic [23:0] er1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ob, ab;
        vecs[0] = '{32'h12345600, 32'hABCDEF00, 32, 1'b0,
                    24'h123456, 24'hABCDEF, 24'h2468AC, 24'h579BDE};
        vecs[1] = '{32'h12345600, 32'hABCDEF00, 32, 1'b1,
                    24'h091A2B, 24'h55E6F7, 24'h123456, 24'hABCDEF};
        vecs[2] = '{32'h80000000, 32'h7FFFFF00, 32, 1'b0,
                    24'h800000, 24'h7FFFFF, 24'h000000, 24'hFFFFFE};
        vecs[3] = '{32'h00008001, 32'h00007FFF, 16, 1'b0,
                    24'h800100, 24'h7FFF00, 24'h000200, 24'hFFFE00};

        rst   = 1'b1;
        lrck  = 1'b1;
        bck   = 1'b0;
        data  = 1'b0;
        ready = 1'b1;
        tick(3);
        chk("reset valid", 32'(v0), 32'd0);
        chk("reset left", 32'(l0), 32'd0);
        chk("reset right", 32'(r0), 32'd0);
        chk("reset overrun", 32'(o0), 32'd0);
        rst = 1'b0;
        tick(2);

        // Partial right slot ahead of the first left start
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1, 1'b0);

        for (int i = 0; i <= 4; i++) begin
            vcnt = 0;
            if (i < 4)
                send_frame(vecs[i].lw, vecs[i].rw, vecs[i].n, vecs[i].ph, 1'b0);
            else
                send_frame(32'h0, 32'h0, 32, 1'b0, 1'b0);
            if (i == 0) begin
                chk("no valid on partial frame", 32'(vcnt), 32'd0);
            end else begin
                chk($sformatf("row%0d valid count", i-1), 32'(vcnt), 32'd1);
                chk($sformatf("row%0d latency", i-1), 32'(vcyc - ref_cyc), 32'd3);
                chk($sformatf("row%0d left d0", i-1), 32'(cl0), 32'(vecs[i-1].el0));
                chk($sformatf("row%0d right d0", i-1), 32'(cr0), 32'(vecs[i-1].er0));
                chk($sformatf("row%0d left d1", i-1), 32'(cl1), 32'(vecs[i-1].el1));
                chk($sformatf("row%0d right d1", i-1), 32'(cr1), 32'(vecs[i-1].er1));
            end
        end

        // Backpressure: hold first pair, overwrite with second, one overrun
        send_frame(32'h00000100, 32'h00000200, 32, 1'b0, 1'b0);
        ready = 1'b0;
        ob = ocnt;
        send_frame(32'h00000300, 32'h00000400, 32, 1'b0, 1'b0);
        chk("bp hold valid", 32'(v0), 32'd1);
        chk("bp hold left", 32'(l0), 32'h000001);
        chk("bp hold right", 32'(r0), 32'h000002);
        chk("bp no overrun yet", 32'(ocnt - ob), 32'd0);
        send_frame(32'h00000500, 32'h00000600, 32, 1'b0, 1'b0);
        chk("bp overwrite valid", 32'(v0), 32'd1);
        chk("bp overwrite left", 32'(l0), 32'h000003);
        chk("bp overwrite right", 32'(r0), 32'h000004);
        chk("bp overrun pulses", 32'(ocnt - ob), 32'd1);
        ab = acc;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        chk("bp drained valid", 32'(v0), 32'd0);
        chk("bp single transfer", 32'(acc - ab), 32'd1);

        // Accept in the very cycle of a commit
        ob = ocnt;
        send_frame(32'h00000700, 32'h00000800, 32, 1'b0, 1'b0);
        chk("sim pre left", 32'(l0), 32'h000005);
        chk("sim pre right", 32'(r0), 32'h000006);
        chk("sim pre valid", 32'(v0), 32'd1);
        send_frame(32'h00000900, 32'h00000A00, 32, 1'b0, 1'b1);
        chk("sim valid stays", 32'(v0), 32'd1);
        chk("sim new left", 32'(l0), 32'h000007);
        chk("sim new right", 32'(r0), 32'h000008);
        chk("sim no overrun", 32'(ocnt - ob), 32'd0);

        // Reset in the middle of a right slot
        for (int i = 0; i < 32; i++) send_bit(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick(1);
        chk("midrst valid", 32'(v0), 32'd0);
        chk("midrst left", 32'(l0), 32'd0);
        chk("midrst right", 32'(r0), 32'd0);
        chk("midrst overrun", 32'(o0), 32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
        vcnt = 0;
        send_frame(32'h11111100, 32'h22222200, 32, 1'b0, 1'b0);
        chk("postrst no early valid", 32'(vcnt), 32'd0);
        send_frame(32'h0, 32'h0, 32, 1'b0, 1'b0);
        chk("postrst valid count", 32'(vcnt), 32'd1);
        chk("postrst left", 32'(cl0), 32'h111111);
        chk("postrst right", 32'(cr0), 32'h222222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
